// File: rtl/arthas_pkg.sv
// Shared types and helpers for the systolic output drain.
package arthas_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_t;

    // Index width for a bank selector; never narrower than one bit.
    function automatic int bank_idx_w(input int n_banks);
        return (n_banks > 1) ? $clog2(n_banks) : 1;
    endfunction

    // Index width for a column selector; never narrower than one bit.
    function automatic int col_idx_w(input int n_cols);
        return (n_cols > 1) ? $clog2(n_cols) : 1;
    endfunction

endpackage

// File: rtl/drain_fifo.sv
// Per-column entry FIFO. A push into a full FIFO is accepted only if the
// same cycle also pops; otherwise it is dropped (caller flags overflow).
module drain_fifo #(
    parameter int W     = 66,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Storage array: no reset needed, contents are only read when non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Read/write pointers with a wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/systolic_out_drain.sv
// Drains per-column systolic array results through one beat stream.
// Each column has a FIFO of whole-column entries (all banks); a round-robin
// arbiter grants a column, then the entry is sent one bank per beat.
// Optional accepted-beat counter enabled by defining DRAIN_BEAT_CNT_EN.
module systolic_out_drain
    import arthas_pkg::*;
#(
    parameter int N_BANKS    = 2,
    parameter int N_COLS     = 4,
    parameter int O_WIDTH    = 33,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_BANKS*N_COLS*O_WIDTH-1:0]    dout,
    input  logic [N_COLS-1:0]                    dout_en,
    output logic [O_WIDTH-1:0]                   m_data,
    output logic [bank_idx_w(N_BANKS)-1:0]       m_bank,
    output logic [col_idx_w(N_COLS)-1:0]         m_col,
    output logic                                 m_valid,
    output logic                                 m_last,
    input  logic                                 m_ready,
    output logic [N_COLS-1:0]                    ovf,
    input  logic                                 ovf_clr,
    output logic                                 busy,
    output logic [31:0]                          beat_cnt
);
    localparam int BW = bank_idx_w(N_BANKS);
    localparam int CW = col_idx_w(N_COLS);
    localparam int EW = N_BANKS * O_WIDTH;

    drain_state_t               state, state_nxt;
    logic [CW-1:0]              grant, last_grant, pick, cand;
    logic                       found;
    logic [BW-1:0]              bank;
    logic [N_COLS-1:0][EW-1:0]  wr_entry, head;
    logic [N_COLS-1:0]          full, empty, pop;
    logic                       accept, last_beat;

    assign accept    = (state == SEND) && m_ready;
    assign last_beat = (bank == BW'(N_BANKS - 1));
    assign busy      = !(&empty) || (state == SEND);

    genvar c, b;
    generate
        for (c = 0; c < N_COLS; c++) begin : g_col
            // Gather column c of every bank into one FIFO entry, bank 0 in the LSBs.
            for (b = 0; b < N_BANKS; b++) begin : g_bank
                assign wr_entry[c][b*O_WIDTH +: O_WIDTH] = dout[(b*N_COLS + c)*O_WIDTH +: O_WIDTH];
            end

            assign pop[c] = accept && last_beat && (grant == CW'(c));

            drain_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (dout_en[c]),
                .wdata (wr_entry[c]),
                .pop   (pop[c]),
                .rdata (head[c]),
                .full  (full[c]),
                .empty (empty[c])
            );

            // Sticky overflow: a dropped push sets it, and beats a same-cycle clear.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                                   ovf[c] <= 1'b0;
                else if (dout_en[c] && full[c] && !pop[c]) ovf[c] <= 1'b1;
                else if (ovf_clr)                          ovf[c] <= 1'b0;
            end
        end
    endgenerate

    // Round-robin pick: first non-empty column after the last grant.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = last_grant;
        for (int i = 0; i < N_COLS; i++) begin
            cand = (cand == CW'(N_COLS - 1)) ? '0 : cand + CW'(1);
            if (!found && !empty[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: every entry ends in IDLE, so grants are never back-to-back.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found)               state_nxt = SEND;
            SEND:    if (accept && last_beat) state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Grant and bank cursor; bank only moves on an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant      <= '0;
            last_grant <= CW'(N_COLS - 1);
            bank       <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                grant      <= pick;
                last_grant <= pick;
                bank       <= '0;
            end
        end else if (accept) begin
            bank <= last_beat ? '0 : bank + BW'(1);
        end
    end

    // FSM outputs: beat fields are forced to zero whenever no beat is offered.
    always_comb begin
        m_valid = 1'b0;
        m_data  = '0;
        m_bank  = '0;
        m_col   = '0;
        m_last  = 1'b0;
        if (state == SEND) begin
            m_valid = 1'b1;
            m_data  = head[grant][bank*O_WIDTH +: O_WIDTH];
            m_bank  = bank;
            m_col   = grant;
            m_last  = last_beat;
        end
    end

`ifdef DRAIN_BEAT_CNT_EN
    // Accepted-beat counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         beat_cnt <= '0;
        else if (accept) beat_cnt <= beat_cnt + 32'd1;
    end
`else
    assign beat_cnt = '0;
`endif

endmodule
